multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Control FSM for the multicycle RISC-V datapath: one shared memory, one ALU, and the IR/OldPC/A/WriteData/ALUOut/Data registers.
- Sequences each instruction through Fetch, Decode, Execute, Memory and Writeback states, one state per clock.
- Drives every datapath mux select and write enable, including ALUControl.
- Supports lw, sw, R-type, I-type ALU, beq and jal.
- Adds a MemReady handshake so memory accesses can stall.

Parameters:
- STATE_W, 4, width of the state register and of the StateOut debug port.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  1  IR[30].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  enables the IR and OldPC load.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  out  2  00 = WriteData, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RegWrite  out  1  register file write enable.
- IllegalInstr  out  1  high while in the ERROR state.
- StateOut  out  STATE_W  current state encoding, for debug.

Behaviour:
- Reset:
  - The state register resets asynchronously to FETCH.
  - While rst_n = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0; other outputs follow the FETCH decode.
  - Reset asserted mid-instruction aborts it immediately; the first cycle after release is FETCH.
- Output logic:
  - All outputs are a Moore decode of state except PCWrite (uses Zero), the MemReady-gated enables, ImmSrc and ALUControl.
  - PCWrite = (Branch & Zero) | PCUpdate.
  - Unlisted outputs are 0 in each state.
- States (outputs -> next state):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite = PCUpdate = MemReady. If MemReady -> DECODE, else stay.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> ERROR
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op = lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Stay until MemReady, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, held until MemReady -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - ERROR: IllegalInstr=1, all enables 0; stays in ERROR until reset.
- Cycle counts with MemReady always high: lw 5, sw 4, R/I 4, beq 3, jal 4.
  - Each MemReady-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle; a stall has no other side effects.
- ImmSrc decode from op:
  - lw and I-type = 00
  - sw = 01
  - beq = 10
  - jal = 11
  - others = 00
- ALU decoder:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub if op[5] & funct7, else add (addi is never sub)
    - 010: slt
    - 110: or
    - 111: and
    - other: add
  - ALUOp 11 -> add.
- StateOut encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ERROR=15
  - Codes 11–14 are unused; if reached, next state is FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum and its encodings
  - the opcode constants
  - the ALUOp and ALUControl codes
  - the ResultSrc, ALUSrcA, ALUSrcB and ImmSrc select codes
- One sub-module, mc_alu_decoder: combinational; inputs ALUOp, op[5], funct3, funct7; output ALUControl.
- The FSM and the ImmSrc decode stay in multicycle_control_unit.

Test Plan:
- lw, MemReady tied high:
  - StateOut sequence 0, 1, 2, 3, 4, 0.
  - RegWrite=1 with ResultSrc=01 only in state 4.
  - IRWrite and PCWrite high only in the FETCH cycle.
- sw with MemReady low for 2 cycles in MEMWRITE: MemWrite high for 3 consecutive cycles, AdrSrc=1 throughout, then FETCH; RegWrite never 1.
- beq: in BEQ, Zero=1 -> PCWrite=1 and ALUControl=001; repeat with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- R-type ALUControl in EXECR:
  - funct3=000, funct7=1 -> 001
  - funct3=111 -> 010
  - funct3=010 -> 101
- addi (op 0010011) with funct7=1 -> ALUControl=000.
- jal: JAL state asserts PCWrite with ALUSrcA=01, ALUSrcB=10, then ALUWB writes the register, then FETCH.
- Illegal opcode 1111111:
  - DECODE -> ERROR (15); IllegalInstr=1 and all enables 0 for 10 or more cycles.
  - rst_n low for 1 cycle, then release -> FETCH.
  - Separately, rst_n pulsed low in MEMREAD -> state immediately 0 and MemWrite, RegWrite, PCWrite, IRWrite all 0 during reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state encodings, opcodes and select codes for the multicycle control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps ALUOp plus instruction fields to the ALU operation
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [2:0] alucontrol
);
  logic [2:0] funct_op;
  // Only R-type (op5 set) may select sub; addi with a set bit 30 stays add
  always_comb begin
    funct_op = (funct3 == 3'b000) ? ((op5 & funct7) ? ALU_SUB : ALU_ADD) :
               (funct3 == 3'b010) ? ALU_SLT :
               (funct3 == 3'b110) ? ALU_OR  :
               (funct3 == 3'b111) ? ALU_AND : ALU_ADD;
    alucontrol = (aluop == ALUOP_SUB)   ? ALU_SUB  :
                 (aluop == ALUOP_FUNCT) ? funct_op : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing fetch/decode/execute/memory/writeback
// for the multicycle RISC-V datapath, with MemReady stalls on memory states.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               RegWrite,
  output logic               IllegalInstr,
  output logic [STATE_W-1:0] StateOut
);
  state_t state, next;
  logic [1:0] aluop;
  logic mem_write, ir_write, reg_write, branch, pc_update;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_FETCH;
    else state <= next;
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:    next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:   next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                         (op == OP_R)   ? S_EXECR :
                         (op == OP_I)   ? S_EXECI :
                         (op == OP_BEQ) ? S_BEQ   :
                         (op == OP_JAL) ? S_JAL   : S_ERROR;
      S_MEMADR:   next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next = S_FETCH;
      S_MEMWRITE: next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next = S_ALUWB;
      S_EXECI:    next = S_ALUWB;
      S_ALUWB:    next = S_FETCH;
      S_BEQ:      next = S_FETCH;
      S_JAL:      next = S_ALUWB;
      S_ERROR:    next = S_ERROR;
      default:    next = S_FETCH;
    endcase
  end
  always_comb begin
    AdrSrc = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    branch = 1'b0;
    pc_update = 1'b0;
    IllegalInstr = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_WD;
    aluop = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB = SRCB_4;
        ResultSrc = RES_ALURESULT;
        ir_write = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        aluop = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_A;
        aluop = ALUOP_SUB;
        branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pc_update = 1'b1;
      end
      S_ERROR: IllegalInstr = 1'b1;
      default: ;
    endcase
  end
  // Enables are masked while reset is held so FETCH's MemReady-driven loads stay off
  assign PCWrite  = rst_n & ((branch & Zero) | pc_update);
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;
  assign ImmSrc = (op == OP_SW)  ? IMM_S :
                  (op == OP_BEQ) ? IMM_B :
                  (op == OP_JAL) ? IMM_J : IMM_I;
  assign StateOut = STATE_W'(state);
  mc_alu_decoder u_alu_dec (
    .aluop(aluop),
    .op5(op[5]),
    .funct3(funct3),
    .funct7(funct7),
    .alucontrol(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed instruction sequences with hand-computed expectations
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7, Zero, MemReady;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] StateOut;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  multicycle_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite),
    .IllegalInstr(IllegalInstr), .StateOut(StateOut)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  // enables packed as {PCWrite, IRWrite, MemWrite, RegWrite}
  task automatic chk(input string tag, input int st, input logic [3:0] en);
    check({tag, ".state"}, 32'(StateOut), st);
    check({tag, ".en"}, {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, {28'd0, en});
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  logic [2:0] r_f3 [4] = '{3'b000, 3'b111, 3'b010, 3'b110};
  logic       r_f7 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0] r_ex [4] = '{3'b001, 3'b010, 3'b101, 3'b011};
  initial begin
    rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0;
    op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0;
    #3;
    chk("reset", 0, 4'b0000);
    check("reset.srcb", 32'(ALUSrcB), 2);
    check("reset.res", 32'(ResultSrc), 2);
    tick;
    rst_n = 1'b1;
    #1;
    chk("lw.fetch", 0, 4'b1100);
    tick; chk("lw.decode", 1, 4'b0000);
    check("lw.decode.srca", 32'(ALUSrcA), 1);
    check("lw.decode.srcb", 32'(ALUSrcB), 1);
    tick; chk("lw.memadr", 2, 4'b0000);
    check("lw.memadr.srca", 32'(ALUSrcA), 2);
    check("lw.immsrc", 32'(ImmSrc), 0);
    tick; chk("lw.memread", 3, 4'b0000);
    check("lw.memread.adr", 32'(AdrSrc), 1);
    tick; chk("lw.memwb", 4, 4'b0001);
    check("lw.memwb.res", 32'(ResultSrc), 1);
    tick; chk("lw.done", 0, 4'b1100);
    MemReady = 1'b0; #1;
    chk("fetch.stall", 0, 4'b0000);
    tick; chk("fetch.stall2", 0, 4'b0000);
    MemReady = 1'b1;
    op = 7'b0100011;
    tick; chk("sw.decode", 1, 4'b0000);
    tick; chk("sw.memadr", 2, 4'b0000);
    check("sw.immsrc", 32'(ImmSrc), 1);
    tick;
    MemReady = 1'b0; #1;
    chk("sw.mw0", 5, 4'b0010);
    check("sw.mw0.adr", 32'(AdrSrc), 1);
    tick; chk("sw.mw1", 5, 4'b0010);
    check("sw.mw1.adr", 32'(AdrSrc), 1);
    tick;
    MemReady = 1'b1; #1;
    chk("sw.mw2", 5, 4'b0010);
    check("sw.mw2.adr", 32'(AdrSrc), 1);
    tick; chk("sw.done", 0, 4'b1100);
    op = 7'b1100011; funct3 = 3'b000;
    for (int z = 1; z >= 0; z--) begin
      Zero = z[0];
      tick; chk("beq.decode", 1, 4'b0000);
      tick; chk("beq.beq", 9, {z[0], 3'b000});
      check("beq.aluctl", 32'(ALUControl), 1);
      check("beq.immsrc", 32'(ImmSrc), 2);
      tick; chk("beq.done", 0, 4'b1100);
    end
    Zero = 1'b0;
    op = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      funct3 = r_f3[i]; funct7 = r_f7[i];
      tick; chk("r.decode", 1, 4'b0000);
      tick; chk("r.execr", 6, 4'b0000);
      check("r.aluctl", 32'(ALUControl), 32'(r_ex[i]));
      check("r.srcb", 32'(ALUSrcB), 0);
      tick; chk("r.aluwb", 8, 4'b0001);
      check("r.aluwb.res", 32'(ResultSrc), 0);
      tick; chk("r.done", 0, 4'b1100);
    end
    op = 7'b0010011; funct3 = 3'b000; funct7 = 1'b1;
    tick; chk("addi.decode", 1, 4'b0000);
    tick; chk("addi.execi", 7, 4'b0000);
    check("addi.aluctl", 32'(ALUControl), 0);
    check("addi.srcb", 32'(ALUSrcB), 1);
    tick; chk("addi.aluwb", 8, 4'b0001);
    tick; chk("addi.done", 0, 4'b1100);
    op = 7'b1101111; funct7 = 1'b0;
    tick; chk("jal.decode", 1, 4'b0000);
    tick; chk("jal.jal", 10, 4'b1000);
    check("jal.srca", 32'(ALUSrcA), 1);
    check("jal.srcb", 32'(ALUSrcB), 2);
    check("jal.immsrc", 32'(ImmSrc), 3);
    tick; chk("jal.aluwb", 8, 4'b0001);
    tick; chk("jal.done", 0, 4'b1100);
    op = 7'b1111111;
    tick; chk("ill.decode", 1, 4'b0000);
    for (int i = 0; i < 11; i++) begin
      tick; chk("ill.error", 15, 4'b0000);
      check("ill.flag", 32'(IllegalInstr), 1);
    end
    rst_n = 1'b0; #1;
    chk("ill.rst", 0, 4'b0000);
    tick;
    rst_n = 1'b1; #1;
    chk("ill.release", 0, 4'b1100);
    check("ill.flag0", 32'(IllegalInstr), 0);
    op = 7'b0000011;
    tick; chk("abort.decode", 1, 4'b0000);
    tick; chk("abort.memadr", 2, 4'b0000);
    tick; chk("abort.memread", 3, 4'b0000);
    rst_n = 1'b0; #1;
    chk("abort.rst", 0, 4'b0000);
    tick; chk("abort.hold", 0, 4'b0000);
    rst_n = 1'b1; #1;
    chk("abort.release", 0, 4'b1100);
    tick; chk("abort.decode2", 1, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
